// File: rtl/interp_fir_mac.sv
// Time-multiplexed interpolation FIR: one shared MAC walks all taps per accepted
// sample strobe, then rounds and saturates the 2s34 sum back to 1s17.
module interp_fir_mac #(
  parameter int unsigned N_TAPS = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sam_clk,
  input  logic signed [17:0] x_in,
  input  logic               coef_we,
  input  logic [4:0]         coef_addr,
  input  logic signed [17:0] coef_data,
  output logic signed [17:0] y,
  output logic               y_valid,
  output logic               busy,
  output logic               overrun
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MAC   = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;

  localparam int unsigned CENTER = (N_TAPS - 1) / 2;
  localparam logic [4:0]  LAST   = 5'(N_TAPS - 1);

  logic [1:0]         state;
  logic [4:0]         k;
  logic signed [40:0] acc;
  logic signed [17:0] d [N_TAPS];
  logic signed [17:0] h [N_TAPS];

  logic signed [35:0] prod;
  logic signed [40:0] acc_rnd;
  logic signed [23:0] acc_sh;
  logic signed [17:0] y_sat;
  logic               accept;
  logic               coef_wr;

  always_comb begin
    busy    = (state != IDLE);
    accept  = sam_clk && (state == IDLE);
    coef_wr = coef_we && (state == IDLE) && (32'(coef_addr) < N_TAPS);
  end

  always_comb begin
    prod    = d[k] * h[k];
    acc_rnd = acc + 41'sd65536;
    acc_sh  = acc_rnd[40:17];
    if (acc_sh > 24'sh01FFFF)
      y_sat = 18'sh1FFFF;
    else if (acc_sh < 24'shFE0000)
      y_sat = 18'sh20000;
    else
      y_sat = acc_sh[17:0];
  end

  // Delay line only moves on an accepted strobe; dropped strobes leave it intact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_TAPS; i++)
        d[i] <= '0;
    end else if (accept) begin
      for (int unsigned i = N_TAPS - 1; i > 0; i--)
        d[i] <= d[i-1];
      d[0] <= x_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_TAPS; i++)
        h[i] <= (i == CENTER) ? 18'sh1FFFF : '0;
    end else if (coef_wr) begin
      h[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      k       <= '0;
      acc     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      if (sam_clk && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sam_clk) begin
            acc   <= '0;
            k     <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc + 41'(prod);
          if (k == LAST)
            state <= ROUND;
          else
            k <= k + 5'd1;
        end
        ROUND: begin
          y       <= y_sat;
          y_valid <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interp_fir_mac.sv
// Directed self-checking bench for interp_fir_mac at the default 17 taps.
module tb_interp_fir_mac;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               sam_clk = 1'b0;
  logic signed [17:0] x_in = '0;
  logic               coef_we = 1'b0;
  logic [4:0]         coef_addr = '0;
  logic signed [17:0] coef_data = '0;
  logic signed [17:0] y;
  logic               y_valid;
  logic               busy;
  logic               overrun;

  int checks   = 0;
  int failures = 0;
  int cnt;
  int first_at;

  interp_fir_mac #(.N_TAPS(17)) dut (
    .clk       (clk),
    .reset     (reset),
    .sam_clk   (sam_clk),
    .x_in      (x_in),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .y         (y),
    .y_valid   (y_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic write_coef(input logic [4:0] a, input logic signed [17:0] v);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = v;
    tick();
    coef_we   = 1'b0;
  endtask

  // Waits (bounded) for y_valid; n0 = cycles already elapsed since the strobe edge.
  task automatic wait_valid(input string tag, input int n0, input logic signed [31:0] exp);
    int n;
    n = n0;
    while (!y_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'sd18);
    chk({tag, "_y"}, 32'(y), exp);
    tick();
    chk({tag, "_pulse"}, 32'(y_valid), 32'sd0);
    chk({tag, "_hold"}, 32'(y), exp);
  endtask

  task automatic run_sample(input string tag, input logic signed [17:0] x, input logic signed [31:0] exp);
    sam_clk = 1'b1;
    x_in    = x;
    tick();
    sam_clk = 1'b0;
    coef_we = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'sd1);
    wait_valid(tag, 0, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    reset = 1'b0;
    chk("rst_y", 32'(y), 32'sd0);
    chk("rst_valid", 32'(y_valid), 32'sd0);
    chk("rst_busy", 32'(busy), 32'sd0);
    chk("rst_overrun", 32'(overrun), 32'sd0);

    // Identity impulse through the default centre tap
    for (int i = 0; i < 10; i++)
      run_sample("identity", (i == 0) ? 18'sd65536 : 18'sd0, (i == 8) ? 32'sd65536 : 32'sd0);

    // h[8]=0, then h[0]=0.5 written on the same edge as the strobe
    write_coef(5'd8, 18'sd0);
    coef_we   = 1'b1;
    coef_addr = 5'd0;
    coef_data = 18'sd65536;
    run_sample("coef_first", 18'sd131071, 32'sd65536);
    run_sample("coef_next1", 18'sd0, 32'sd0);
    run_sample("coef_next2", 18'sd0, 32'sd0);

    // Write during busy is ignored
    do_reset();
    sam_clk = 1'b1;
    x_in    = 18'sd131071;
    tick();
    sam_clk = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    coef_we   = 1'b1;
    coef_addr = 5'd3;
    coef_data = 18'sd1000;
    tick();
    coef_we = 1'b0;
    wait_valid("busywr_pass0", 5, 32'sd0);
    for (int i = 1; i < 8; i++)
      run_sample((i == 3) ? "busywr_tap3" : "busywr_tap", 18'sd0, 32'sd0);
    run_sample("busywr_centre", 18'sd0, 32'sd131070);

    // Overrun: second strobe 5 cycles after the first is dropped
    do_reset();
    chk("ovr_clear", 32'(overrun), 32'sd0);
    sam_clk = 1'b1;
    x_in    = 18'sd65536;
    tick();
    sam_clk = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    sam_clk = 1'b1;
    x_in    = 18'sd12345;
    tick();
    sam_clk = 1'b0;
    chk("ovr_set", 32'(overrun), 32'sd1);
    cnt = 0;
    first_at = -1;
    for (int i = 6; i < 36; i++) begin
      tick();
      if (y_valid) begin
        cnt++;
        if (first_at < 0) first_at = i;
      end
    end
    chk("ovr_nvalid", 32'(cnt), 32'sd1);
    chk("ovr_latency", 32'(first_at), 32'sd18);
    for (int i = 1; i < 8; i++)
      run_sample("ovr_shift", 18'sd0, 32'sd0);
    run_sample("ovr_centre", 18'sd0, 32'sd65536);
    chk("ovr_sticky", 32'(overrun), 32'sd1);

    // Positive saturation
    do_reset();
    for (int i = 0; i < 17; i++) write_coef(5'(i), 18'sh1FFFF);
    run_sample("satp_1", 18'sd131071, 32'sd131070);
    for (int i = 0; i < 3; i++)
      run_sample("satp_clamp", 18'sd131071, 32'sd131071);

    // Negative saturation
    do_reset();
    for (int i = 0; i < 17; i++) write_coef(5'(i), 18'sh1FFFF);
    run_sample("satn_1", 18'sh20000, -32'sd131071);
    for (int i = 0; i < 3; i++)
      run_sample("satn_clamp", 18'sh20000, -32'sd131072);

    // Reset mid-pass
    do_reset();
    run_sample("midrst_pre", 18'sd65536, 32'sd0);
    for (int i = 0; i < 7; i++) run_sample("midrst_pre", 18'sd0, 32'sd0);
    run_sample("midrst_pre8", 18'sd0, 32'sd65536);
    sam_clk = 1'b1;
    x_in    = 18'sd65536;
    tick();
    sam_clk = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'sd0);
    chk("midrst_y", 32'(y), 32'sd0);
    chk("midrst_valid", 32'(y_valid), 32'sd0);
    tick();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (y_valid) cnt++;
    end
    chk("midrst_novalid", 32'(cnt), 32'sd0);
    for (int i = 0; i < 9; i++)
      run_sample("midrst_after", (i == 0) ? 18'sd65536 : 18'sd0, (i == 8) ? 32'sd65536 : 32'sd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interp_fir_mac.md
# interp_fir_mac

Sequential time-multiplexed FIR filter that sits directly downstream of the 2x zero-stuffing up-sampler in the transmit chain and turns its zero-padded 1s17 sample stream into a smoothed, interpolated waveform. One multiply-accumulate (MAC) unit is shared across all taps. It runs on the fast system clock and is paced by the sample-rate enable strobe. Coefficients are run-time writable so the same block serves as pulse-shaping or halfband filter.

## Interface
- `N_TAPS`, default 17: filter length; odd, range 3..31.
- `clk`  in  1: system clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `sam_clk`  in  1: one-`clk`-cycle sample strobe; marks `x_in` as valid.
- `x_in`  in  18 signed: input sample in 1s17 format, i.e. the up-sampler output.
- `coef_we`  in  1: coefficient write enable.
- `coef_addr`  in  5: tap index, 0..`N_TAPS`-1.
- `coef_data`  in  18 signed: coefficient in 1s17 format.
- `y`  out  18 signed: filtered sample in 1s17 format; held between updates.
- `y_valid`  out  1: one-cycle pulse when `y` updates.
- `busy`  out  1: high while a MAC pass is in progress.
- `overrun`  out  1: sticky; set when a strobe is dropped.

## Operation
- **Delay line.** `d[0..N_TAPS-1]` holds 18-bit samples; `d[0]` is the newest.
  - An accepted strobe shifts `d[k] <= d[k-1]` and loads `d[0] <= x_in`.
- **Coefficient RAM.** `h[0..N_TAPS-1]`.
  - Reset value: all 0 except centre tap `h[(N_TAPS-1)/2] = 131071` (identity, delayed).
  - A write lands on the clock edge when `coef_we`=1, `busy`=0 and `coef_addr` < `N_TAPS`.
  - Writes while `busy`=1 or with an out-of-range address are ignored.
- **FSM states.** `IDLE`, `MAC`, `ROUND`.
  - `IDLE`: `sam_clk`=1 → shift delay line, clear accumulator, tap index k=0, go to `MAC`.
  - `MAC`: each cycle `acc <= acc + d[k]*h[k]` and k increments. After k=`N_TAPS`-1 is accumulated, go to `ROUND`.
  - `ROUND`: compute `y`, pulse `y_valid`, go to `IDLE`.
- **Arithmetic.**
  - Product is 36 bits signed (2s34).
  - Accumulator is 41 bits signed; it does not overflow for `N_TAPS` ≤ 31.
  - Rounding: add 2^16 to `acc`, then arithmetic-shift right 17.
  - Saturate the result to [-131072, 131071].
  - Zero-valued samples are multiplied like any other; there is no skipping.
- **Strobe during `busy`** (`MAC` or `ROUND`): the sample is dropped and the delay line is not shifted. `overrun` is set and stays set until `reset`. The pass in progress is unaffected.
- **`busy`** = 1 in `MAC` and `ROUND`, 0 in `IDLE`.
- **Reset values.** Outputs: `y`=0, `y_valid`=0, `busy`=0, `overrun`=0. Internal: delay line all 0, `acc`=0, FSM in `IDLE`, coefficients at their reset value.
- **Reset mid-pass:** aborts the pass immediately; no `y_valid` is produced.

## Timing
- Strobe sampled at edge t; delay line updated at edge t.
- `MAC` occupies edges t+1 .. t+`N_TAPS`.
- `ROUND` is at edge t+`N_TAPS`+1: `y` and `y_valid` register there.
  - Latency from strobe edge to `y_valid` = `N_TAPS`+1 cycles (18 for the default).
- Minimum strobe spacing is `N_TAPS`+2 cycles.
  - A strobe on the same edge `ROUND` completes is dropped.
  - A strobe on the next edge is accepted.
- A coefficient write and a strobe on the same `IDLE` edge are both accepted. The pass started on that edge uses the new coefficient.
- `y_valid` is high for exactly one cycle per accepted strobe.
- `y` holds its value until the next `ROUND`.

## Test plan
- **Reset/identity impulse.** After reset, strobe `x_in`=65536, then 0s, with spacing 20.
  - The 9th `y_valid` (sample index 8) gives `y`=65536.
  - All other `y_valid` give `y`=0.
  - `y_valid` comes 18 cycles after each strobe.
- **Coefficient write.** Write `h[0]`=65536 (0.5), `h[8]`=0; strobe 131071 then 0s.
  - First output `y`=65536: 131071*65536 = 2^33-2^16; +2^16 → 2^33; >>17 = 65536.
  - Subsequent outputs are 0.
- **Saturation.** Set all taps to 131071; strobe 131071 repeatedly.
  - Output climbs and clamps at `y`=131071.
  - With -131072 inputs, it clamps at -131072.
- **Overrun.** Strobe at cycle 0 and again at cycle 5.
  - Second sample dropped; `overrun` goes to 1 and stays 1.
  - Exactly one `y_valid`; delay line shifted once.
- **Write during `busy`.** Write `h[3]`=1000 mid-pass; the write is ignored. A readback pass with an impulse shows tap 3 output = 0.
- **Reset mid-pass.** Assert `reset` 5 cycles after a strobe.
  - `busy`, `y`, `y_valid` drop to 0 at once.
  - The next strobe behaves as the first after reset.
